oursring_resp_router: RTL

- Response-side counterpart of the ring request arbiter.
- Records which input (master) port was granted each AW and AR handshake, in grant order.
- Routes the single downstream B and R response streams back to the owning master port.
- Assumes in-order responses per channel; R bursts are tracked via rlast.
- Back-pressures the arbiter through full flags when outstanding tracking is exhausted.

---
 rtl/oursring_resp_pkg.sv | 18 +
 rtl/oursring_resp_idx_fifo.sv | 61 ++++++
 rtl/oursring_resp_router.sv | 112 +++++++++++
 3 files changed

// File: rtl/oursring_resp_pkg.sv
// Shared helpers for the ring response router: port-index width and one-hot encode.
package oursring_resp_pkg;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest set bit wins, so a malformed multi-hot grant still maps to one port.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/oursring_resp_idx_fifo.sv
// Grant-order FIFO of master port indices; head is read combinationally for zero-latency routing.
module oursring_resp_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign overflow = push & full;
    assign head_idx = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_idx;
    end

endmodule

// File: rtl/oursring_resp_router.sv
// Routes downstream B/R responses back to the granted master in grant order.
// Optional sticky error flags enabled by defining OURSRING_RESP_ROUTER_ERR_EN.
module oursring_resp_router
    import oursring_resp_pkg::*;
#(
    parameter int N_IN_PORT = 3,
    parameter int DEPTH     = 4,
    parameter int B_W       = 2,
    parameter int R_W       = 66
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN_PORT-1:0] aw_hs,
    input  logic [N_IN_PORT-1:0] ar_hs,
    output logic                 aw_full,
    output logic                 ar_full,
    input  logic                 o_bvalid,
    output logic                 o_bready,
    input  logic [B_W-1:0]       o_b,
    output logic [N_IN_PORT-1:0] i_bvalid,
    input  logic [N_IN_PORT-1:0] i_bready,
    output logic [B_W-1:0]       i_b,
    input  logic                 o_rvalid,
    input  logic                 o_rlast,
    output logic                 o_rready,
    input  logic [R_W-1:0]       o_r,
    output logic [N_IN_PORT-1:0] i_rvalid,
    output logic                 i_rlast,
    input  logic [N_IN_PORT-1:0] i_rready,
    output logic [R_W-1:0]       i_r,
    output logic [1:0]           err
);
    localparam int IDX_W = idx_width(N_IN_PORT);

    logic [IDX_W-1:0]     aw_idx, ar_idx, w_head, r_head;
    logic                 w_empty, r_empty, w_ovf, r_ovf;
    logic                 w_pop, r_pop;
    logic [N_IN_PORT-1:0] w_sel, r_sel;

    assign aw_idx = IDX_W'(onehot_to_idx(32'(aw_hs)));
    assign ar_idx = IDX_W'(onehot_to_idx(32'(ar_hs)));

    oursring_resp_idx_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (|aw_hs),
        .push_idx (aw_idx),
        .pop      (w_pop),
        .head_idx (w_head),
        .empty    (w_empty),
        .full     (aw_full),
        .overflow (w_ovf)
    );

    oursring_resp_idx_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (|ar_hs),
        .push_idx (ar_idx),
        .pop      (r_pop),
        .head_idx (r_head),
        .empty    (r_empty),
        .full     (ar_full),
        .overflow (r_ovf)
    );

    // One-hot owner select; all zero while the FIFO is empty so orphans stall.
    for (genvar gi = 0; gi < N_IN_PORT; gi++) begin : g_sel
        assign w_sel[gi] = ~w_empty & (w_head == IDX_W'(gi));
        assign r_sel[gi] = ~r_empty & (r_head == IDX_W'(gi));
    end

    assign i_bvalid = w_sel & {N_IN_PORT{o_bvalid}};
    assign o_bready = |(w_sel & i_bready);
    assign i_rvalid = r_sel & {N_IN_PORT{o_rvalid}};
    assign o_rready = |(r_sel & i_rready);

    assign w_pop = o_bvalid & o_bready;
    assign r_pop = o_rvalid & o_rready & o_rlast;

    assign i_b     = o_b;
    assign i_r     = o_r;
    assign i_rlast = o_rlast;

`ifdef OURSRING_RESP_ROUTER_ERR_EN
    logic [1:0] err_q, err_d;
    logic       orphan;

    assign orphan = (o_bvalid & w_empty) | (o_rvalid & r_empty);

    always_comb begin
        err_d = err_q | {orphan, w_ovf | r_ovf};
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = w_ovf ^ r_ovf;
    assign err = 2'b00;
`endif

`ifndef SYNTHESIS
    a_aw_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(aw_hs));
    a_ar_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ar_hs));
`endif

endmodule
